// File: rtl/pool_pkg.sv
// Shared definitions for the pooling-stage sequencer: widths, state codes,
// legal kernel sizes and the latched per-layer configuration record.
package pool_pkg;

    localparam int MAX_BITS_POOL = 3;
    localparam int ROW_CNT_W     = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [MAX_BITS_POOL-1:0] KS_1 = MAX_BITS_POOL'(1);
    localparam logic [MAX_BITS_POOL-1:0] KS_2 = MAX_BITS_POOL'(2);
    localparam logic [MAX_BITS_POOL-1:0] KS_4 = MAX_BITS_POOL'(4);

    // target holds the resolved row count (0 already mapped to the tile size)
    typedef struct packed {
        logic                     enable;
        logic [MAX_BITS_POOL-1:0] kernel;
        logic [ROW_CNT_W-1:0]     target;
    } pool_cfg_t;

    function automatic logic kernel_legal(input logic [MAX_BITS_POOL-1:0] ks);
        return (ks == KS_1) || (ks == KS_2) || (ks == KS_4);
    endfunction

endpackage

// File: rtl/pool_ctrl_if.sv
// Control/status bundle between the layer controller, the upstream row stream
// and the pooling sequencer. The sequencer uses the slave modport.
interface pool_ctrl_if;
    import pool_pkg::*;

    logic                     start;
    logic                     cfg_enable_pool;
    logic [MAX_BITS_POOL-1:0] cfg_kernel_size;
    logic [ROW_CNT_W-1:0]     cfg_num_rows;
    logic                     up_data_available;
    logic                     enable_pool;
    logic [MAX_BITS_POOL-1:0] kernel_size;
    logic                     in_data_available;
    logic                     busy;
    logic                     done;
    logic                     err_kernel;
    logic                     err_timeout;
    logic [ROW_CNT_W-1:0]     row_count;

    modport master (
        output start, cfg_enable_pool, cfg_kernel_size, cfg_num_rows, up_data_available,
        input  enable_pool, kernel_size, in_data_available, busy, done,
               err_kernel, err_timeout, row_count
    );

    modport slave (
        input  start, cfg_enable_pool, cfg_kernel_size, cfg_num_rows, up_data_available,
        output enable_pool, kernel_size, in_data_available, busy, done,
               err_kernel, err_timeout, row_count
    );
endinterface

// File: rtl/pool_ctrl_watchdog.sv
// Stall counter for the pooling sequencer: fires on the TIMEOUT_CYCLES-th
// consecutive stalled cycle since the last accepted row.
module pool_ctrl_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic stall,
    output logic fire
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (stall) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign fire = stall && !clear && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/pool_ctrl.sv
// Pooling-stage sequencer: latches layer config on start, gates upstream rows
// into the datapath, drains one cycle, then pulses done. Define
// POOL_CTRL_TIMEOUT_EN to add the stall watchdog and err_timeout.
module pool_ctrl
    import pool_pkg::*;
#(
    parameter int MAT_MUL_SIZE = 8
`ifdef POOL_CTRL_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic        clk,
    input  logic        reset,
    pool_ctrl_if.slave  bus
);
    logic [2:0]           state_reg, state_next;
    pool_cfg_t            cfg_reg;
    logic [ROW_CNT_W-1:0] row_count_reg;
    logic                 err_kernel_reg;
    logic                 last_in_reg;
    logic                 active, row_accept, last_row, start_accept, bad_kernel, stall_fire;

    assign active       = (state_reg == S_ARM) || (state_reg == S_RUN);
    assign start_accept = (state_reg == S_IDLE) && bus.start;
    assign bad_kernel   = bus.cfg_enable_pool && !kernel_legal(bus.cfg_kernel_size);
    // the compare against target keeps the counter saturated, never wrapping
    assign row_accept   = active && bus.up_data_available && (row_count_reg < cfg_reg.target);
    assign last_row     = row_accept && ((row_count_reg + ROW_CNT_W'(1)) == cfg_reg.target);

`ifdef POOL_CTRL_TIMEOUT_EN
    logic err_timeout_reg;

    pool_ctrl_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clear (!active || row_accept),
        .stall (active && !bus.up_data_available),
        .fire  (stall_fire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_timeout_reg <= 1'b0;
        end else if (start_accept) begin
            err_timeout_reg <= 1'b0;
        end else if (stall_fire) begin
            err_timeout_reg <= 1'b1;
        end
    end

    assign bus.err_timeout = err_timeout_reg;
`else
    assign stall_fire      = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = bad_kernel ? S_DONE : S_ARM;
                end
            end
            S_ARM, S_RUN: begin
                if (last_row) begin
                    state_next = S_DRAIN;
                end else if (stall_fire) begin
                    state_next = S_DONE;
                end else if (row_accept) begin
                    state_next = S_RUN;
                end
            end
            S_DRAIN: state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            cfg_reg        <= '0;
            row_count_reg  <= '0;
            err_kernel_reg <= 1'b0;
            last_in_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_accept) begin
                cfg_reg.enable <= bus.cfg_enable_pool;
                cfg_reg.kernel <= bus.cfg_kernel_size;
                cfg_reg.target <= (bus.cfg_num_rows == '0) ? ROW_CNT_W'(MAT_MUL_SIZE)
                                                           : bus.cfg_num_rows;
                row_count_reg  <= '0;
                err_kernel_reg <= bad_kernel;
            end else if (row_accept) begin
                row_count_reg <= row_count_reg + ROW_CNT_W'(1);
            end
            if (active) begin
                last_in_reg <= bus.up_data_available;
            end
        end
    end

    // DRAIN replays the last gated valid so the datapath output register settles
    assign bus.in_data_available = active ? bus.up_data_available
                                 : ((state_reg == S_DRAIN) ? last_in_reg : 1'b0);
    assign bus.enable_pool = cfg_reg.enable && (active || (state_reg == S_DRAIN));
    assign bus.kernel_size = cfg_reg.kernel;
    assign bus.busy        = (state_reg != S_IDLE);
    assign bus.done        = (state_reg == S_DONE);
    assign bus.err_kernel  = err_kernel_reg;
    assign bus.row_count   = row_count_reg;
endmodule
